// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter state encoding and
// the clocks-per-bit helper used to size the bit timer.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with first-word fall-through: rd_data always shows
// the head entry, so the consumer pops and uses it on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high, fed from a small FIFO so queued
// bytes go out back-to-back with no idle gap between frames.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit time
//   DATA  | shifting out 8 data bits, LSB first
//   STOP  | stop bit (high); chains straight into START if more is queued
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD       = 115200,
  parameter int CLK_HZ     = 25000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             tx_next;
  logic             busy_next;
  logic             pop;
  logic             bit_done;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;

  assign ready    = !fifo_full;
  assign bit_done = (cnt == CNT_LAST);

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (valid && ready),
    .wr_data(data),
    .rd_en  (pop),
    .rd_data(fifo_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
          else                               bit_next   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // tx and busy are registered, so they are derived from the next state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx      <= tx_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-rate instance plus a CLK_HZ=8/BAUD=2
// instance, with a line monitor decoding frames from the default instance.
module tb_uart_tx;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [7:0] data_s;
  logic       valid_s;
  logic       ready_s;
  logic       tx_s;
  logic       busy_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc [32];

  logic [7:0] mon_bytes [$];
  int         mon_starts [$];
  int         mon_stop_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .busy (busy)
  );

  uart_tx #(
    .BAUD      (2),
    .CLK_HZ    (8),
    .FIFO_DEPTH(4)
  ) dut_slow (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data_s),
    .valid(valid_s),
    .ready(ready_s),
    .tx   (tx_s),
    .busy (busy_s)
  );

  // Line receiver: detects the start edge, samples every bit at mid-point.
  initial begin
    bit         act;
    int         cnt;
    int         st;
    logic [9:0] sh;
    act = 1'b0;
    cnt = 0;
    st  = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
          st  = cyc;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          sh[cnt / CPB] = tx;
          if (cnt / CPB == 9) begin
            act = 1'b0;
            if (sh[0] !== 1'b0 || sh[9] !== 1'b1) mon_stop_err++;
            mon_bytes.push_back(sh[8:1]);
            mon_starts.push_back(st);
          end
        end
      end
    end
  end

  task automatic mon_clear();
    mon_bytes.delete();
    mon_starts.delete();
    mon_stop_err = 0;
  endtask

  // Holds valid with an incrementing byte stream, logging the accept cycle.
  task automatic push_stream(input int n, input int base_val);
    int   k;
    int   guard;
    logic will;
    k     = 0;
    guard = 0;
    @(negedge clk);
    data  = 8'(base_val);
    valid = 1'b1;
    while (k < n && guard < 40000) begin
      will = ready;
      @(negedge clk);
      guard++;
      if (will) begin
        acc_cyc[k] = cyc;
        k++;
        data = 8'(base_val + k);
        if (k == n) valid = 1'b0;
      end
    end
    valid = 1'b0;
    n_tests++;
    if (k != n) begin
      n_fail++;
      $display("FAIL push_stream: accepted %0d want %0d", k, n);
    end
  endtask

  task automatic wait_rx(input int n, input int limit);
    int g;
    g = 0;
    while ((mon_bytes.size() < n || busy !== 1'b0) && g < limit) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (g >= limit) begin
      n_fail++;
      $display("FAIL wait_rx timeout: got %0d frames want %0d", mon_bytes.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; data = '0; valid_s = 1'b0; data_s = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (tx !== 1'b1)     begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_tests++; if (tx_s !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_s: got %b want 1", tx_s); end
    n_tests++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy_s: got %b want 0", busy_s); end
    n_tests++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s: got %b want 1", ready_s); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] fr;
    int         err;
    fr = {1'b1, 8'h55, 1'b0};
    mon_clear();
    @(negedge clk); data = 8'h55; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_accept_edge: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    n_tests++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_pop_edge: tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    for (int b = 0; b < 10; b++) begin
      err = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== fr[b] || busy !== 1'b1) err++;
        @(negedge clk);
      end
      n_tests++;
      if (err != 0) begin
        n_fail++; $display("FAIL single_bit%0d: %0d bad cycles want 0 (level %b)", b, err, fr[b]);
      end
    end
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    n_tests++;
    if (mon_bytes.size() != 1 || mon_bytes[0] !== 8'h55) begin
      n_fail++; $display("FAIL single_rx: %0d frames, want one frame of 55", mon_bytes.size());
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    mon_clear();
    @(negedge clk); data = 8'hA5; valid = 1'b1;
    @(negedge clk); data = 8'h3C;
    @(negedge clk); valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 5000; i++) begin
      if (busy === 1'b1) hi++;
      @(negedge clk);
    end
    n_tests++;
    if (hi != 4340) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 4340", hi); end
    n_tests++;
    if (mon_bytes.size() != 2 || mon_bytes[0] !== 8'hA5 || mon_bytes[1] !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_rx: %0d frames, want A5 then 3C", mon_bytes.size());
    end else begin
      n_tests++;
      if (mon_starts[1] - mon_starts[0] != 2170) begin
        n_fail++; $display("FAIL b2b_gap: start spacing %0d want 2170", mon_starts[1] - mon_starts[0]);
      end
    end
    n_tests++;
    if (mon_stop_err != 0) begin n_fail++; $display("FAIL b2b_framing: %0d bad frames want 0", mon_stop_err); end
  endtask

  task automatic test_backpressure();
    int err;
    mon_clear();
    push_stream(8, 1);
    n_tests++;
    if (acc_cyc[4] - acc_cyc[0] != 4) begin
      n_fail++; $display("FAIL bp_first5: span %0d want 4", acc_cyc[4] - acc_cyc[0]);
    end
    n_tests++;
    if (acc_cyc[5] - acc_cyc[0] != 2172) begin
      n_fail++; $display("FAIL bp_sixth: accept offset %0d want 2172", acc_cyc[5] - acc_cyc[0]);
    end
    n_tests++;
    if (acc_cyc[6] - acc_cyc[5] != 2170) begin
      n_fail++; $display("FAIL bp_seventh: accept spacing %0d want 2170", acc_cyc[6] - acc_cyc[5]);
    end
    wait_rx(8, 20000);
    err = 0;
    for (int i = 0; i < 8; i++)
      if (i >= mon_bytes.size() || mon_bytes[i] !== 8'(i + 1)) err++;
    n_tests++;
    if (err != 0 || mon_bytes.size() != 8) begin
      n_fail++; $display("FAIL bp_order: %0d wrong bytes, %0d frames, want 01..08", err, mon_bytes.size());
    end
  endtask

  task automatic test_wrap_around();
    int err;
    mon_clear();
    push_stream(20, 0);
    n_tests++;
    if (acc_cyc[19] - acc_cyc[0] != 32552) begin
      n_fail++; $display("FAIL wrap_last_accept: offset %0d want 32552", acc_cyc[19] - acc_cyc[0]);
    end
    wait_rx(20, 20000);
    err = 0;
    for (int i = 0; i < 20; i++)
      if (i >= mon_bytes.size() || mon_bytes[i] !== 8'(i)) err++;
    n_tests++;
    if (err != 0 || mon_bytes.size() != 20) begin
      n_fail++; $display("FAIL wrap_order: %0d wrong bytes, %0d frames, want 00..13", err, mon_bytes.size());
    end
    n_tests++;
    if (mon_stop_err != 0) begin n_fail++; $display("FAIL wrap_framing: %0d bad frames want 0", mon_stop_err); end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    int err;
    int g;
    mon_clear();
    @(negedge clk); data = 8'hF0; valid = 1'b1;
    @(negedge clk); data = 8'h11; c0 = cyc;
    @(negedge clk); data = 8'h22;
    @(negedge clk); valid = 1'b0;
    g = 0;
    while (cyc < c0 + 1 + 4 * CPB + 100 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_bit3: tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_async: tx=%b busy=%b ready=%b want 1 0 1", tx, busy, ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_clear();
    err = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) err++;
    end
    n_tests++;
    if (err != 0) begin n_fail++; $display("FAIL rst_line_quiet: %0d active cycles want 0", err); end
    n_tests++;
    if (mon_bytes.size() != 0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_flushed: %0d frames ready=%b want 0 frames ready=1", mon_bytes.size(), ready);
    end
  endtask

  task automatic test_min_rate();
    logic [9:0] fr;
    int         err;
    fr = {1'b1, 8'h81, 1'b0};
    @(negedge clk); data_s = 8'h81; valid_s = 1'b1;
    @(negedge clk); valid_s = 1'b0;
    n_tests++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
      n_fail++; $display("FAIL slow_accept_edge: tx=%b busy=%b want tx=1 busy=0", tx_s, busy_s);
    end
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      err = 0;
      for (int c = 0; c < 4; c++) begin
        if (tx_s !== fr[b] || busy_s !== 1'b1) err++;
        @(negedge clk);
      end
      n_tests++;
      if (err != 0) begin
        n_fail++; $display("FAIL slow_bit%0d: %0d bad cycles want 0 (level %b)", b, err, fr[b]);
      end
    end
    n_tests++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
      n_fail++; $display("FAIL slow_end: tx=%b busy=%b want tx=1 busy=0", tx_s, busy_s);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_wrap_around();
    test_reset_mid_frame();
    test_min_rate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
